// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES-CTR sequencer: FSM encoding, key-length codes,
// block width and the counter-increment helper.
package aes_ctr_pkg;

  localparam int BLOCK_W           = 128;
  localparam int CTR_WIDTH_DEFAULT = 32;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GEN  = 2'd2,
    ST_HAVE = 2'd3
  } ctr_state_t;

  // Bits under mask count modulo their width; bits outside the mask (the nonce) are kept.
  function automatic logic [BLOCK_W-1:0] ctr_incr(input logic [BLOCK_W-1:0] blk,
                                                  input logic [BLOCK_W-1:0] mask);
    return (blk & ~mask) | ((blk + BLOCK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_out_slice.sv
// One-entry AXI-Stream register slice for data+last; a load and a drain may happen
// in the same cycle, so back-to-back words flow without a bubble.
module aes_ctr_out_slice
  import aes_ctr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               load_last,
  input  logic               drain,
  output logic [BLOCK_W-1:0] data,
  output logic               last,
  output logic               valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      last  <= load_last;
      valid <= 1'b1;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer: owns the counter block, drives one shared encipher core per word
// and XORs the keystream into the AXI-Stream path through a one-entry output slice.
//
//   state | meaning
//   IDLE  | no message; waits for cfg_start
//   ARM   | waits for key_ready, then pulses core_next with core_block = ctr
//   GEN   | core busy; latch keystream when core_ready returns
//   HAVE  | keystream held; accept one input word when the output slot can take it
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [BLOCK_W-1:0] cfg_iv,
  input  logic               cfg_keylen,
  input  logic               key_ready,
  input  logic [BLOCK_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [BLOCK_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               core_next,
  output logic               core_keylen,
  output logic [BLOCK_W-1:0] core_block,
  input  logic [BLOCK_W-1:0] core_result,
  input  logic               core_ready,
  output logic               busy,
  output logic               ctr_wrap,
  output logic [31:0]        block_count
);

  localparam logic [BLOCK_W-1:0] LOW_MASK =
    (CTR_WIDTH >= BLOCK_W) ? {BLOCK_W{1'b1}} : ((BLOCK_W'(1) << CTR_WIDTH) - BLOCK_W'(1));

  ctr_state_t         state, state_n;
  logic [BLOCK_W-1:0] ctr;
  logic [BLOCK_W-1:0] ks;
  logic               fire_n;
  logic               start_ok;
  logic               in_hs;
  logic               out_hs;
  logic               ctr_at_max;

  assign start_ok      = (state == ST_IDLE) && cfg_start;
  assign s_axis_tready = (state == ST_HAVE) && (!m_axis_tvalid || m_axis_tready);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign ctr_at_max    = ((ctr & LOW_MASK) == LOW_MASK);
  assign core_block    = ctr;
  assign busy          = (state != ST_IDLE) || m_axis_tvalid;

  // core_next is registered: fire_n looks one cycle ahead so the pulse lands in the
  // first ARM cycle when key_ready is already high, and never repeats in ARM.
  always_comb begin
    state_n = state;
    fire_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          state_n = ST_ARM;
          fire_n  = key_ready;
        end
      end
      ST_ARM: begin
        if (core_next) state_n = ST_GEN;
        else           fire_n  = key_ready;
      end
      ST_GEN: begin
        if (core_ready) state_n = ST_HAVE;
      end
      ST_HAVE: begin
        if (in_hs) begin
          state_n = s_axis_tlast ? ST_IDLE : ST_ARM;
          fire_n  = !s_axis_tlast && key_ready;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ctr         <= '0;
      ks          <= '0;
      core_next   <= 1'b0;
      core_keylen <= AES_128_BIT_KEY;
      ctr_wrap    <= 1'b0;
    end else begin
      state     <= state_n;
      core_next <= fire_n;
      ctr_wrap  <= in_hs && ctr_at_max;
      if (start_ok) begin
        ctr         <= cfg_iv;
        core_keylen <= cfg_keylen;
      end else if (in_hs) begin
        ctr <= ctr_incr(ctr, LOW_MASK);
      end
      if (state == ST_GEN && core_ready) ks <= core_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                block_count <= '0;
    else if (start_ok)                        block_count <= '0;
    else if (out_hs && (block_count != '1))   block_count <= block_count + 32'd1;
  end

  aes_ctr_out_slice u_out_slice (
    .clk       (clk),
    .reset     (reset),
    .load      (in_hs),
    .load_data (s_axis_tdata ^ ks),
    .load_last (s_axis_tlast),
    .drain     (m_axis_tready),
    .data      (m_axis_tdata),
    .last      (m_axis_tlast),
    .valid     (m_axis_tvalid)
  );

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Bench for aes_ctr_sequencer: a stand-in encipher core with random latency, randomized
// messages and sink backpressure, checked against a counter/keystream scoreboard.
module tb_aes_ctr_sequencer;

  localparam logic [127:0] F51_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] F51_PT = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] F51_CT = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] F51_KS = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start, cfg_keylen, key_ready;
  logic [127:0] cfg_iv;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         core_next, core_keylen, core_ready;
  logic [127:0] core_block, core_result;
  logic         busy, ctr_wrap;
  logic [31:0]  block_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } exp_t;
  exp_t exp_q[$];

  logic [127:0] cur_iv;
  logic         cur_keylen;
  int           word_idx, core_idx, wrap_seen;
  logic         bp_hold;
  int           lat_fixed;

  always #5 clk = ~clk;

  aes_ctr_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_iv(cfg_iv), .cfg_keylen(cfg_keylen), .key_ready(key_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block),
    .core_result(core_result), .core_ready(core_ready),
    .busy(busy), .ctr_wrap(ctr_wrap), .block_count(block_count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: the real F.5.1 keystream for that IV under AES-128, a fixed mix otherwise.
  function automatic logic [127:0] fake_ks(input logic [127:0] b, input logic kl);
    if (b == F51_IV && kl == 1'b0) return F51_KS;
    return {b[63:0] ^ 64'h0f1e2d3c4b5a6978, b[127:64] + 64'h9e3779b97f4a7c15}
           ^ {4{kl ? 32'h5a5aa5a5 : 32'h3cc3c33c}};
  endfunction

  function automatic logic [127:0] ctr_at(input logic [127:0] iv, input int i);
    logic [31:0] lo;
    lo = iv[31:0] + 32'(i);
    return {iv[127:32], lo};
  endfunction

  // Encipher core model: ready drops the edge after next, returns after 1..5 cycles.
  logic [127:0] core_blk_l;
  logic         core_kl_l;
  int           core_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready  <= 1'b1;
      core_result <= '0;
      core_cnt    <= 0;
    end else if (core_next) begin
      core_ready <= 1'b0;
      core_blk_l <= core_block;
      core_kl_l  <= core_keylen;
      core_cnt   <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
    end else if (!core_ready) begin
      if (core_cnt <= 1) begin
        core_ready  <= 1'b1;
        core_result <= fake_ks(core_blk_l, core_kl_l);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (core_next) begin
        chk("core_block", core_block, ctr_at(cur_iv, core_idx));
        chk("core_keylen", core_keylen, cur_keylen);
        core_idx++;
      end
      if (ctr_wrap) wrap_seen++;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) chk("unexpected_out", m_axis_tvalid, 1'b0);
        else begin
          chk("m_tdata", m_axis_tdata, exp_q[0].d);
          chk("m_tlast", m_axis_tlast, exp_q[0].l);
          if (m_axis_tready) void'(exp_q.pop_front());
        end
        if (!m_axis_tready) chk("s_tready_full", s_axis_tready, 1'b0);
      end
    end
  end

  task automatic start_msg(input logic [127:0] iv, input logic kl);
    @(posedge clk); #1;
    cfg_start  = 1'b1;
    cfg_iv     = iv;
    cfg_keylen = kl;
    cur_iv     = iv;
    cur_keylen = kl;
    word_idx   = 0;
    core_idx   = 0;
    wrap_seen  = 0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] d, input logic last);
    int t;
    exp_t e;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    e.d = d ^ fake_ks(ctr_at(cur_iv, word_idx), cur_keylen);
    e.l = last;
    exp_q.push_back(e);
    word_idx++;
    @(negedge clk);
    while (!s_axis_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("in_hs_timeout", 1'(t < 500), 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic finish_msg(input int n);
    int t, wraps;
    t = 0;
    wraps = 0;
    for (int i = 0; i < n; i++)
      if (cur_iv[31:0] + 32'(i) == 32'hffffffff) wraps++;
    while ((busy || exp_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 1'(t < 1000), 1'b1);
    @(negedge clk);
    chk("busy_end", busy, 1'b0);
    chk("s_tready_idle", s_axis_tready, 1'b0);
    chk("block_count", block_count, 128'(n));
    chk("ctr_wraps", 128'(wrap_seen), 128'(wraps));
    chk("core_ops", 128'(core_idx), 128'(n));
  endtask

  task automatic run_msg(input logic [127:0] iv, input logic kl, input int n);
    start_msg(iv, kl);
    for (int i = 0; i < n; i++)
      send_word({$urandom, $urandom, $urandom, $urandom}, i == n - 1);
    finish_msg(n);
  endtask

  task automatic run_f51();
    start_msg(F51_IV, 1'b0);
    @(negedge clk);
    chk("cfg_to_next", core_next, 1'b1);
    chk("f51_model", F51_PT ^ fake_ks(F51_IV, 1'b0), F51_CT);
    send_word(F51_PT, 1'b1);
    finish_msg(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    logic [127:0] iv;
    int t;
    reset = 1'b1;
    cfg_start = 1'b0; cfg_iv = '0; cfg_keylen = 1'b0; key_ready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    bp_hold = 1'b0; lat_fixed = 0;
    cur_iv = '0; cur_keylen = 1'b0; word_idx = 0; core_idx = 0; wrap_seen = 0;

    @(negedge clk);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_core_next", core_next, 1'b0);
    chk("rst_core_block", core_block, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_block_count", block_count, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_f51();

    // Counter wrap across two words
    run_msg({96'h0123456789abcdef01234567, 32'hffffffff}, 1'b1, 2);

    // Gating on key_ready
    key_ready = 1'b0;
    start_msg({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gate_core_next", core_next, 1'b0);
      chk("gate_s_tready", s_axis_tready, 1'b0);
    end
    @(posedge clk); #1;
    key_ready = 1'b1;
    @(negedge clk);
    chk("gate_same_cycle", core_next, 1'b0);
    @(negedge clk);
    chk("gate_next_after", core_next, 1'b1);
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    finish_msg(1);

    // Backpressure over a 4-word message
    bp_hold = 1'b1;
    fork
      begin
        repeat (20) @(posedge clk);
        bp_hold = 1'b0;
      end
    join_none
    run_msg({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4);

    // cfg_start in HAVE is ignored
    start_msg({$urandom, $urandom, $urandom, 32'hfffffffe}, 1'b0);
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("have_timeout", 1'(t < 500), 1'b1);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_iv = ~cur_iv; cfg_keylen = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    finish_msg(3);

    // Randomized messages
    for (int m = 0; m < 6; m++) begin
      iv = {$urandom, $urandom, $urandom, $urandom};
      if (m % 2 == 1) iv[31:0] = 32'hffffffff - 32'($urandom_range(0, 3));
      run_msg(iv, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
    end

    // Asynchronous reset while the core is generating, with an output word pending
    bp_hold = 1'b1;
    lat_fixed = 8;
    start_msg({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    t = 0;
    @(negedge clk);
    while (!core_next && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("gen_timeout", 1'(t < 50), 1'b1);
    chk("pending_before_rst", m_axis_tvalid, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("arst_m_tdata", m_axis_tdata, '0);
    chk("arst_m_tlast", m_axis_tlast, 1'b0);
    chk("arst_s_tready", s_axis_tready, 1'b0);
    chk("arst_core_next", core_next, 1'b0);
    chk("arst_core_block", core_block, '0);
    chk("arst_core_keylen", core_keylen, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_block_count", block_count, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    bp_hold = 1'b0;
    lat_fixed = 0;
    run_f51();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
